// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and encodings for the multicycle control unit
package multicycle_pkg;

  // Main FSM states
  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH,
    UNKNOWN
  } state_t;

  // Instr[27:26] opcode classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // ALUControl codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALUSrcA selects
  localparam logic [1:0] SRCA_RD1 = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Register index whose write also redirects the PC
  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - instruction fields in, datapath controls out
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic [3:0]       Rd;
  logic             IRWrite;
  logic             AdrSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUControl;
  logic [1:0]       FlagW;
  logic             RegW;
  logic             MemW;
  logic             NextPC;
  logic             PCS;
  logic             Illegal;
  logic [CNT_W-1:0] InstrCount;

  // Controller side
  modport master (
    input  Op, Funct, Rd,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
    output FlagW, RegW, MemW, NextPC, PCS, Illegal, InstrCount
  );

  // Datapath side
  modport slave (
    output Op, Funct, Rd,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
    input  FlagW, RegW, MemW, NextPC, PCS, Illegal, InstrCount
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - combinational cmd/S decode for the ALU and flags
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic       alu_op,
  input  logic [4:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       bad_cmd
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       arith;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);

  // Map cmd to ALU operation; CMP subtracts but never writes back
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    bad_cmd     = 1'b0;
    if (alu_op) begin
      unique case (cmd)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_OR;
        CMD_CMP: begin
          alu_control = ALU_SUB;
          no_write    = 1'b1;
        end
        default: bad_cmd = 1'b1;
      endcase
      flag_w = {s_bit, s_bit & arith};
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore main FSM sequencing the multicycle ARM datapath
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;

  logic       ir_write;
  logic       adr_src;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       branch;
  logic       reg_w;
  logic       mem_w;
  logic       next_pc;
  logic       retire;
  logic       alu_eval;

  logic [1:0] dec_alu_control;
  logic [1:0] dec_flag_w;
  logic       dec_no_write;
  logic       dec_bad_cmd;

  // ALUOp is derived from state alone so the decoder never feeds back into itself
  assign alu_op   = (state == EXECUTER) || (state == EXECUTEI) || (state == ALUWB);
  assign alu_eval = (state == EXECUTER) || (state == EXECUTEI);
  assign retire   = (state == MEMWB) || (state == MEMWR) || (state == ALUWB) || (state == BRANCH);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.Funct[4:0]),
    .alu_control (dec_alu_control),
    .flag_w      (dec_flag_w),
    .no_write    (dec_no_write),
    .bad_cmd     (dec_bad_cmd)
  );

  // State register; reset lands in FETCH immediately, abandoning any partial instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Retired-instruction counter, bumped on the final cycle of each real instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (retire) begin
      count <= count + CNT_W'(1);
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    next_state = FETCH;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    src_a      = SRCA_RD1;
    src_b      = SRCB_RD2;
    result_src = RES_ALUOUT;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    next_pc    = 1'b0;
    unique case (state)
      FETCH: begin
        ir_write   = 1'b1;
        src_a      = SRCA_PC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        next_pc    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        src_a      = SRCA_PC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        unique case (bus.Op)
          OP_MEM:  next_state = MEMADR;
          OP_DP:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   next_state = BRANCH;
          default: next_state = UNKNOWN;
        endcase
      end
      MEMADR: begin
        src_b      = SRCB_IMM;
        next_state = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src    = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECUTER: begin
        next_state = ALUWB;
      end
      EXECUTEI: begin
        src_b      = SRCB_IMM;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_w = ~dec_no_write & ~dec_bad_cmd;
      end
      BRANCH: begin
        src_b      = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch     = 1'b1;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  assign bus.IRWrite    = ir_write & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = dec_alu_control;
  assign bus.FlagW      = (alu_eval && !reset) ? dec_flag_w : 2'b00;
  assign bus.RegW       = reg_w & ~reset;
  assign bus.MemW       = mem_w & ~reset;
  assign bus.NextPC     = next_pc & ~reset;
  assign bus.PCS        = (branch | (reg_w & (bus.Rd == REG_PC))) & ~reset;
  assign bus.Illegal    = (state == UNKNOWN) || ((state == ALUWB) && dec_bad_cmd);
  assign bus.InstrCount = count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench against a per-instruction reference model
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [CNT_W-1:0] exp_count;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,RegW,MemW,NextPC,PCS,Illegal}
  function automatic logic [16:0] vec(input logic ir, input logic adr, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs, input logic [1:0] ac,
                                      input logic [1:0] fw, input logic rw, input logic mw,
                                      input logic np, input logic pcs, input logic ill);
    return {ir, adr, sa, sb, rs, ac, fw, rw, mw, np, pcs, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl,
            bus.FlagW, bus.RegW, bus.MemW, bus.NextPC, bus.PCS, bus.Illegal};
  endfunction

  // Expected per-cycle control vectors for one instruction, straight from the instruction semantics
  function automatic void expect_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                                       output logic [16:0] q[$]);
    logic [3:0] cmd;
    logic       s;
    logic       known;
    logic       arith;
    logic [1:0] ac;
    logic       rw;
    q = {};
    q.push_back(vec(1, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0));
    q.push_back(vec(0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    cmd = funct[4:1];
    s   = funct[0];
    case (op)
      2'b01: begin
        q.push_back(vec(0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
        if (funct[0]) begin
          q.push_back(vec(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0));
          q.push_back(vec(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 0, 0, rd == 4'd15, 0));
        end else begin
          q.push_back(vec(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, 0));
        end
      end
      2'b00: begin
        known = 1'b1;
        case (cmd)
          4'b0100: ac = 2'b00;
          4'b0010: ac = 2'b01;
          4'b0000: ac = 2'b10;
          4'b1100: ac = 2'b11;
          4'b1010: ac = 2'b01;
          default: begin ac = 2'b00; known = 1'b0; end
        endcase
        arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        rw    = known && (cmd != 4'b1010);
        q.push_back(vec(0, 0, 2'b00, funct[5] ? 2'b01 : 2'b00, 2'b00, ac, {s, s & arith}, 0, 0, 0, 0, 0));
        q.push_back(vec(0, 0, 2'b00, 2'b00, 2'b00, ac, 2'b00, rw, 0, 0, rw && (rd == 4'd15), !known));
      end
      2'b10: q.push_back(vec(0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0));
      default: q.push_back(vec(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1));
    endcase
  endfunction

  // Starts at a negedge with the DUT in FETCH; stops early (still at a negedge) when abort_at >= 0
  task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input int abort_at);
    logic [16:0] q[$];
    int          n;
    expect_instr(op, funct, rd, q);
    bus.Op    = op;
    bus.Funct = funct;
    bus.Rd    = rd;
    #1;
    check({tag, "_count"}, 32'(bus.InstrCount), 32'(exp_count));
    n = (abort_at >= 0) ? abort_at : q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) #1;
      check($sformatf("%s_c%0d", tag, i), 32'(observed()), 32'(q[i]));
      @(negedge clk);
    end
    if (abort_at < 0 && op != 2'b11) exp_count = exp_count + 1'b1;
  endtask

  logic [1:0]  r_op;
  logic [5:0]  r_funct;
  logic [3:0]  r_rd;
  logic [3:0]  legal_cmds [5];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_count = '0;
    reset     = 1'b1;
    bus.Op    = 2'b00;
    bus.Funct = 6'b0;
    bus.Rd    = 4'd0;
    legal_cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    repeat (2) @(negedge clk);
    #1;
    check("reset_out", 32'(observed()), 32'(vec(0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0)));
    check("reset_count", 32'(bus.InstrCount), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr("add_s", 2'b00, 6'b001001, 4'd1, -1);
    run_instr("cmp", 2'b00, 6'b010101, 4'd0, -1);
    run_instr("ldr", 2'b01, 6'b000001, 4'd2, -1);
    run_instr("str", 2'b01, 6'b000000, 4'd3, -1);
    run_instr("b", 2'b10, 6'b000000, 4'd0, -1);
    run_instr("mov_pc", 2'b00, 6'b111000, 4'd15, -1);
    run_instr("ldr_pc", 2'b01, 6'b100001, 4'd15, -1);
    run_instr("op11", 2'b11, 6'b001001, 4'd15, -1);
    run_instr("badcmd", 2'b00, 6'b011111, 4'd15, -1);
    run_instr("subi", 2'b00, 6'b100100, 4'd4, -1);

    // Abort an LDR while it is in MEMRD
    run_instr("ldr_abort", 2'b01, 6'b000001, 4'd5, 3);
    #1;
    check("abort_memrd", 32'(observed()), 32'(vec(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0)));
    reset = 1'b1;
    #1;
    check("abort_in_reset", 32'(observed()), 32'(vec(0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0)));
    check("abort_count", 32'(bus.InstrCount), 32'd0);
    @(negedge clk);
    check("abort_next", 32'(observed()), 32'(vec(0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0)));
    reset = 1'b0;
    exp_count = '0;

    // Random mix; enough retirements to wrap the 4-bit counter several times
    for (int k = 0; k < 80; k++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_funct = 6'($urandom);
      if ($urandom_range(0, 4) != 0) r_funct[4:1] = legal_cmds[$urandom_range(0, 4)];
      r_rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr($sformatf("rnd%0d", k), r_op, r_funct, r_rd, -1);
    end
    #1;
    check("final_count", 32'(bus.InstrCount), 32'(exp_count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
